// File: rtl/pipeline_pkg.sv
// Shared pipeline constants: register file geometry and forward-select encodings.
package pipeline_pkg;

    localparam int unsigned NUM_REGS   = 32;
    localparam int unsigned REG_ADDR_W = 5;

    localparam logic [REG_ADDR_W-1:0] REG_X0 = '0;

    // Forward-select encodings used by the operand-forwarding mux.
    typedef enum logic [1:0] {
        FWD_NONE   = 2'b00,
        FWD_EX_MEM = 2'b01,
        FWD_MEM_WB = 2'b10
    } fwd_sel_e;

endpackage

// File: rtl/scoreboard_bits.sv
// Pending-destination scoreboard for the single in-flight multi-cycle op.
// Owns the pending vector and the in-flight destination register.
module scoreboard_bits
    import pipeline_pkg::*;
#(
    parameter int unsigned NUM_REGS   = pipeline_pkg::NUM_REGS,
    parameter int unsigned REG_ADDR_W = pipeline_pkg::REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  mc_done,
    input  logic                  clr_en,
    input  logic                  issue,
    input  logic                  set_en,
    input  logic [REG_ADDR_W-1:0] wr_rd,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    input  logic [REG_ADDR_W-1:0] rd,
    output logic [NUM_REGS-1:0]   pending,
    output logic [NUM_REGS-1:0]   eff,
    output logic                  rs1_pend,
    output logic                  rs2_pend,
    output logic                  rd_pend
);

    localparam logic [NUM_REGS-1:0] ONE = {{(NUM_REGS-1){1'b0}}, 1'b1};

    logic [NUM_REGS-1:0]   pending_q, pending_d;
    logic [NUM_REGS-1:0]   release_mask;
    logic [REG_ADDR_W-1:0] mc_rd_q;

    // A completing op's register is already on the MEM/WB path this cycle.
    assign release_mask = mc_done ? (ONE << mc_rd_q) : '0;
    assign eff          = pending_q & ~release_mask;

    assign rs1_pend = eff[rs1];
    assign rs2_pend = eff[rs2];
    assign rd_pend  = eff[rd];
    assign pending  = pending_q;

    // Next pending vector: clear first so a same-register set wins; x0 never tracked.
    always_comb begin
        pending_d = pending_q;
        if (clr_en) begin
            pending_d[mc_rd_q] = 1'b0;
        end
        if (set_en) begin
            pending_d[wr_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    // Scoreboard state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q <= '0;
            mc_rd_q   <= '0;
        end else begin
            pending_q <= pending_d;
            if (issue) begin
                mc_rd_q <= wr_rd;
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard unit: load-use and multi-cycle RAW/WAW/structural stall generation.
// Remaining dependencies are left to the EX/MEM and MEM/WB forwarding paths.
module hazard_scoreboard
    import pipeline_pkg::*;
#(
    parameter int unsigned NUM_REGS   = pipeline_pkg::NUM_REGS,
    parameter int unsigned REG_ADDR_W = pipeline_pkg::REG_ADDR_W,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_is_mc,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_flush,
    input  logic                  mc_done,
    output logic                  stall,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  id_ex_bubble,
    output logic                  mc_issue,
    output logic                  mc_busy,
    output logic [NUM_REGS-1:0]   pending,
    output logic [CNT_W-1:0]      stall_count
);

    localparam logic [REG_ADDR_W-1:0] X0 = REG_ADDR_W'(REG_X0);

    logic                mc_busy_q;
    logic [CNT_W-1:0]    stall_count_q;
    logic [NUM_REGS-1:0] eff;
    logic                rs1_pend, rs2_pend, rd_pend;
    logic                load_use, sb_raw, sb_waw, mc_struct, issue;
    logic                mc_clr, rd_set;

    assign mc_clr = mc_done & mc_busy_q;
    assign rd_set = mc_issue & id_reg_write & (id_rd != X0);

    scoreboard_bits #(
        .NUM_REGS  (NUM_REGS),
        .REG_ADDR_W(REG_ADDR_W)
    ) u_bits (
        .clk     (clk),
        .reset_n (reset_n),
        .mc_done (mc_done),
        .clr_en  (mc_clr),
        .issue   (mc_issue),
        .set_en  (rd_set),
        .wr_rd   (id_rd),
        .rs1     (id_rs1),
        .rs2     (id_rs2),
        .rd      (id_rd),
        .pending (pending),
        .eff     (eff),
        .rs1_pend(rs1_pend),
        .rs2_pend(rs2_pend),
        .rd_pend (rd_pend)
    );

    // Hazard detection and stall/issue decode; a flush overrides any stall.
    always_comb begin
        load_use  = ex_mem_read & (ex_rd != X0) &
                    ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
        sb_raw    = (id_use_rs1 & rs1_pend) | (id_use_rs2 & rs2_pend);
        sb_waw    = id_reg_write & (id_rd != X0) & rd_pend;
        mc_struct = id_is_mc & mc_busy_q & ~mc_done;
        stall     = id_valid & ~ex_flush & (load_use | sb_raw | sb_waw | mc_struct);
        issue     = id_valid & ~ex_flush & ~stall;
        mc_issue  = issue & id_is_mc;
    end

    assign pc_write     = ~stall;
    assign if_id_write  = ~stall;
    assign id_ex_bubble = stall;
    assign mc_busy      = mc_busy_q;
    assign stall_count  = stall_count_q;

    // Busy flag (issue wins over completion) and wrapping stall counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mc_busy_q     <= 1'b0;
            stall_count_q <= '0;
        end else begin
            if (mc_issue) begin
                mc_busy_q <= 1'b1;
            end else if (mc_clr) begin
                mc_busy_q <= 1'b0;
            end
            if (stall) begin
                stall_count_q <= stall_count_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: vector table, directed corner cases,
// and randomized traffic against an in-flight-op reference model.
module tb_hazard_scoreboard;

    localparam int CNT_W = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        id_valid, id_use_rs1, id_use_rs2, id_reg_write, id_is_mc;
    logic [4:0]  id_rs1, id_rs2, id_rd, ex_rd;
    logic        ex_mem_read, ex_flush, mc_done;
    logic        stall, pc_write, if_id_write, id_ex_bubble, mc_issue, mc_busy;
    logic [31:0] pending;
    logic [CNT_W-1:0] stall_count;

    int total  = 0;
    int passed = 0;

    // Reference model: at most one in-flight op, its destination (0 = none), stall tally.
    bit m_busy;
    int m_dest;
    int m_cnt;

    hazard_scoreboard #(
        .NUM_REGS  (32),
        .REG_ADDR_W(5),
        .CNT_W     (CNT_W)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .id_rd       (id_rd),
        .id_reg_write(id_reg_write),
        .id_is_mc    (id_is_mc),
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .ex_flush    (ex_flush),
        .mc_done     (mc_done),
        .stall       (stall),
        .pc_write    (pc_write),
        .if_id_write (if_id_write),
        .id_ex_bubble(id_ex_bubble),
        .mc_issue    (mc_issue),
        .mc_busy     (mc_busy),
        .pending     (pending),
        .stall_count (stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [31:0] m_pending();
        return (m_dest != 0) ? (32'd1 << m_dest) : 32'd0;
    endfunction

    task automatic model_reset();
        m_busy = 1'b0;
        m_dest = 0;
        m_cnt  = 0;
    endtask

    typedef struct {
        logic       v;
        logic [4:0] rs1, rs2;
        logic       u1, u2;
        logic [4:0] rd;
        logic       rw, mc, mr;
        logic [4:0] exrd;
        logic       fl, done;
    } stim_t;

    // One clock cycle: drive, check combinational outputs, clock, check state.
    task automatic step(input stim_t s, output logic a_stall, output logic a_issue);
        int  blocked;
        bit  lu, raw, waw, st, m_stall, m_issue;
        @(negedge clk);
        id_valid = s.v;  id_rs1 = s.rs1; id_rs2 = s.rs2;
        id_use_rs1 = s.u1; id_use_rs2 = s.u2; id_rd = s.rd;
        id_reg_write = s.rw; id_is_mc = s.mc; ex_mem_read = s.mr;
        ex_rd = s.exrd; ex_flush = s.fl; mc_done = s.done;
        #1;
        blocked = (m_busy && !s.done) ? m_dest : 0;
        lu  = s.mr && s.exrd != 0 &&
              ((s.u1 && s.rs1 == s.exrd) || (s.u2 && s.rs2 == s.exrd));
        raw = blocked != 0 && ((s.u1 && int'(s.rs1) == blocked) ||
                               (s.u2 && int'(s.rs2) == blocked));
        waw = blocked != 0 && s.rw && int'(s.rd) == blocked;
        st  = m_busy && s.mc && !s.done;
        m_stall = s.v && !s.fl && (lu || raw || waw || st);
        m_issue = s.v && !s.fl && !m_stall && s.mc;
        chk("stall", 32'(stall), 32'(m_stall));
        chk("pc_write", 32'(pc_write), 32'(!m_stall));
        chk("if_id_write", 32'(if_id_write), 32'(!m_stall));
        chk("id_ex_bubble", 32'(id_ex_bubble), 32'(m_stall));
        chk("mc_issue", 32'(mc_issue), 32'(m_issue));
        a_stall = stall;
        a_issue = mc_issue;
        @(posedge clk);
        if (s.done && !m_busy) $display("note: protocol error, mc_done while idle (ignored)");
        if (s.done && m_busy) begin
            m_busy = 1'b0;
            m_dest = 0;
        end
        if (m_issue) begin
            m_busy = 1'b1;
            m_dest = (s.rw && s.rd != 0) ? int'(s.rd) : 0;
        end
        if (m_stall) m_cnt = (m_cnt + 1) % (1 << CNT_W);
        #1;
        chk("pending", pending, m_pending());
        chk("mc_busy", 32'(mc_busy), 32'(m_busy));
        chk("stall_count", 32'(stall_count), 32'(m_cnt));
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{v: 0, rs1: 0, rs2: 0, u1: 0, u2: 0, rd: 0, rw: 0, mc: 0, mr: 0,
              exrd: 0, fl: 0, done: 0};
        return s;
    endfunction

    // Instruction in ID: rd <- op rs1, rs2.
    function automatic stim_t instr(input int rd, input int rs1, input int rs2, input bit mc);
        stim_t s;
        s = idle();
        s.v = 1; s.rd = 5'(rd); s.rw = 1; s.mc = mc;
        s.rs1 = 5'(rs1); s.rs2 = 5'(rs2); s.u1 = 1; s.u2 = 1;
        return s;
    endfunction

    typedef struct {
        stim_t s;
        logic  exp_stall;
    } vec_t;

    initial begin
        vec_t  vecs[8];
        stim_t s;
        logic  a_st, a_is;
        logic [CNT_W-1:0] cnt_before;

        model_reset();
        reset_n = 1'b0;
        s = idle();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        id_rd = 0; id_reg_write = 0; id_is_mc = 0; ex_mem_read = 0; ex_rd = 0;
        ex_flush = 0; mc_done = 0;
        #12;
        chk("rst_pending", pending, 32'd0);
        chk("rst_busy", 32'(mc_busy), 32'd0);
        chk("rst_count", 32'(stall_count), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_pc_write", 32'(pc_write), 32'd1);
        chk("rst_mc_issue", 32'(mc_issue), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Load-use table, nothing in flight.
        vecs[0].s = instr(6, 5, 1, 0); vecs[0].s.mr = 1; vecs[0].s.exrd = 5; vecs[0].exp_stall = 1;
        vecs[1].s = instr(6, 1, 5, 0); vecs[1].s.mr = 1; vecs[1].s.exrd = 5; vecs[1].exp_stall = 1;
        vecs[2].s = instr(6, 5, 5, 0); vecs[2].s.u1 = 0; vecs[2].s.u2 = 0;
        vecs[2].s.mr = 1; vecs[2].s.exrd = 5; vecs[2].exp_stall = 0;
        vecs[3].s = instr(6, 0, 0, 0); vecs[3].s.mr = 1; vecs[3].s.exrd = 0; vecs[3].exp_stall = 0;
        vecs[4].s = instr(6, 5, 1, 0); vecs[4].s.mr = 0; vecs[4].s.exrd = 5; vecs[4].exp_stall = 0;
        vecs[5].s = instr(6, 5, 1, 0); vecs[5].s.mr = 1; vecs[5].s.exrd = 5;
        vecs[5].s.fl = 1; vecs[5].exp_stall = 0;
        vecs[6].s = instr(6, 5, 1, 0); vecs[6].s.mr = 1; vecs[6].s.exrd = 5;
        vecs[6].s.v = 0; vecs[6].exp_stall = 0;
        vecs[7].s = instr(6, 4, 3, 0); vecs[7].s.mr = 1; vecs[7].s.exrd = 5; vecs[7].exp_stall = 0;
        for (int i = 0; i < 8; i++) begin
            step(vecs[i].s, a_st, a_is);
            chk($sformatf("vec%0d_stall", i), 32'(a_st), 32'(vecs[i].exp_stall));
        end

        // Load-use: one stall cycle, then the load is in EX/MEM.
        cnt_before = stall_count;
        s = instr(6, 5, 1, 0); s.mr = 1; s.exrd = 5;
        step(s, a_st, a_is);
        chk("lu_stall", 32'(a_st), 32'd1);
        chk("lu_count", 32'(stall_count), 32'(cnt_before + 1'b1));
        step(instr(6, 5, 1, 0), a_st, a_is);
        chk("lu_release", 32'(a_st), 32'd0);

        // Multi-cycle RAW on x7.
        step(instr(7, 1, 2, 1), a_st, a_is);
        chk("mul7_issue", 32'(a_is), 32'd1);
        chk("mul7_pending", pending, 32'h80);
        for (int i = 0; i < 4; i++) begin
            step(instr(8, 7, 7, 0), a_st, a_is);
            chk("raw7_stall", 32'(a_st), 32'd1);
        end
        s = instr(8, 7, 7, 0); s.done = 1;
        step(s, a_st, a_is);
        chk("raw7_done_stall", 32'(a_st), 32'd0);
        chk("raw7_done_pending", pending, 32'd0);

        // Back-to-back: div x9 in flight, mul x10 waits for completion.
        step(instr(9, 1, 2, 1), a_st, a_is);
        step(instr(10, 1, 2, 1), a_st, a_is);
        chk("b2b_struct_stall", 32'(a_st), 32'd1);
        s = instr(10, 1, 2, 1); s.done = 1;
        step(s, a_st, a_is);
        chk("b2b_issue", 32'(a_is), 32'd1);
        chk("b2b_busy", 32'(mc_busy), 32'd1);
        chk("b2b_pending", pending, 32'h400);

        // Same-rd set wins: x3 completes while a new op to x3 issues.
        s = instr(3, 1, 2, 1); s.done = 1;
        step(s, a_st, a_is);
        chk("x3_first_pending", pending, 32'h8);
        s = instr(3, 1, 2, 1); s.done = 1;
        step(s, a_st, a_is);
        chk("x3_same_stall", 32'(a_st), 32'd0);
        chk("x3_same_pending", pending, 32'h8);
        chk("x3_same_busy", 32'(mc_busy), 32'd1);
        s = idle(); s.done = 1;
        step(s, a_st, a_is);

        // mul x0 never tracked; flushed hazard neither stalls nor issues.
        step(instr(0, 1, 2, 1), a_st, a_is);
        chk("x0_pending", pending, 32'd0);
        chk("x0_busy", 32'(mc_busy), 32'd1);
        s = idle(); s.done = 1;
        step(s, a_st, a_is);
        cnt_before = stall_count;
        s = instr(6, 5, 1, 1); s.mr = 1; s.exrd = 5; s.fl = 1;
        step(s, a_st, a_is);
        chk("flush_stall", 32'(a_st), 32'd0);
        chk("flush_issue", 32'(a_is), 32'd0);
        chk("flush_count", 32'(stall_count), 32'(cnt_before));

        // Async reset with mul x4 in flight, then a stray completion.
        step(instr(4, 1, 2, 1), a_st, a_is);
        chk("x4_pending", pending, 32'h10);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        chk("arst_pending", pending, 32'd0);
        chk("arst_busy", 32'(mc_busy), 32'd0);
        chk("arst_count", 32'(stall_count), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        s = idle(); s.done = 1;
        step(s, a_st, a_is);
        chk("stray_pending", pending, 32'd0);
        chk("stray_busy", 32'(mc_busy), 32'd0);

        // Randomized traffic; mc_done only while the model has an op in flight.
        for (int n = 0; n < 1500; n++) begin
            s.v    = ($urandom_range(0, 7) != 0);
            s.rs1  = 5'($urandom_range(0, 7));
            s.rs2  = 5'($urandom_range(0, 7));
            s.u1   = 1'($urandom_range(0, 1));
            s.u2   = 1'($urandom_range(0, 1));
            s.rd   = 5'($urandom_range(0, 7));
            s.rw   = ($urandom_range(0, 3) != 0);
            s.mc   = ($urandom_range(0, 3) == 0);
            s.mr   = ($urandom_range(0, 2) == 0);
            s.exrd = 5'($urandom_range(0, 7));
            s.fl   = ($urandom_range(0, 7) == 0);
            s.done = m_busy && ($urandom_range(0, 3) == 0);
            step(s, a_st, a_is);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
